// File: rtl/step_controller_pkg.sv
// Shared types and constants for the step controller.
// State encoding is fixed so that debug tooling can decode the raw state value.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Number of flops in the button synchronizer chain
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/step_controller_if.sv
// Button / core-control bundle between the board-side logic and step_controller.
// Optional breakpoint signals exist only when STEP_BREAKPOINT_EN is defined.
// There is no valid/ready handshake here: step_pb/run_pb are level inputs whose
// rising edges are detected inside the controller, and every output is a plain
// per-cycle status level (bp_hit is a single-cycle pulse).
interface step_controller_if
    import step_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             step_pb;
    logic             run_pb;
    logic             cpu_en;
    logic             halted;
    logic             running;
    logic [CNT_W-1:0] step_count;
    state_t           dbg_state;
`ifdef STEP_BREAKPOINT_EN
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             bp_hit;
`endif

`ifdef STEP_BREAKPOINT_EN
    modport master (
        output step_pb, run_pb, pc, bp_addr, bp_valid,
        input  cpu_en, halted, running, step_count, dbg_state, bp_hit
    );
    modport slave (
        input  step_pb, run_pb, pc, bp_addr, bp_valid,
        output cpu_en, halted, running, step_count, dbg_state, bp_hit
    );
`else
    modport master (
        output step_pb, run_pb,
        input  cpu_en, halted, running, step_count, dbg_state
    );
    modport slave (
        input  step_pb, run_pb,
        output cpu_en, halted, running, step_count, dbg_state
    );
`endif

endinterface

// File: rtl/step_controller_pulse_sync.sv
// pulse_sync: brings an asynchronous push-button level into the clk domain and
// turns each rising edge into a registered one-cycle request.
// Rise on i_pb -> o_req high after the 3rd clk edge.
module pulse_sync
    import step_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_pb,
    output logic o_req
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_req;

    // Synchronizer chain, previous synchronized level, and registered rise pulse.
    // All cleared on reset, so a button held through reset yields one request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_last <= 1'b0;
            r_req  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pb};
            r_last <= r_sync[SYNC_STAGES-1];
            r_req  <= r_sync[SYNC_STAGES-1] & ~r_last;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/step_controller.sv
// step_controller: drives the single-cycle core's clock-enable in halt,
// single-step (STEP_CYCLES enables per press) and free-run modes, and counts
// executed cycles for the display.
// Optional feature macro: STEP_BREAKPOINT_EN (PC breakpoint halting RUN).
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    step_controller_if.slave bus
);

    localparam int BW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(STEP_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [BW-1:0]    r_burst;
    logic [BW-1:0]    w_burst_next;
    logic [CNT_W-1:0] r_step_count;
    logic             w_step_req;
    logic             w_run_req;
    logic             w_bp_hit;
    logic             w_cpu_en;

    pulse_sync u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .i_pb  (bus.step_pb),
        .o_req (w_step_req)
    );

    pulse_sync u_run_sync (
        .clk   (clk),
        .rst   (rst),
        .i_pb  (bus.run_pb),
        .o_req (w_run_req)
    );

    // State and burst counter registers; reset aborts any burst at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HALT;
            r_burst <= '0;
        end else begin
            r_state <= w_next;
            r_burst <= w_burst_next;
        end
    end

    // Next-state logic: RUN beats STEP in HALT, requests are dropped while stepping.
    always_comb begin
        w_next       = r_state;
        w_burst_next = r_burst;
        case (r_state)
            ST_HALT: begin
                if (w_run_req) begin
                    w_next = ST_RUN;
                end else if (w_step_req) begin
                    w_next       = ST_STEP;
                    w_burst_next = BURST_LAST;
                end
            end
            ST_STEP: begin
                if (r_burst == '0) begin
                    w_next = ST_HALT;
                end else begin
                    w_burst_next = r_burst - 1'b1;
                end
            end
            ST_RUN: begin
                if (w_run_req || w_bp_hit) begin
                    w_next = ST_HALT;
                end
            end
            default: w_next = ST_HALT;
        endcase
    end

`ifdef STEP_BREAKPOINT_EN
    logic r_bp_armed;

    // Disarm on entry to RUN so resuming at the breakpoint executes it; arm after one RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bp_armed <= 1'b0;
        end else if ((r_state != ST_RUN) && (w_next == ST_RUN)) begin
            r_bp_armed <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_bp_armed <= 1'b1;
        end
    end

    assign w_bp_hit   = (r_state == ST_RUN) & r_bp_armed & bus.bp_valid & (bus.pc == bus.bp_addr);
    assign bus.bp_hit = w_bp_hit;
`else
    assign w_bp_hit = 1'b0;
`endif

    // A breakpoint hit suppresses the enable in the same cycle it is seen.
    assign w_cpu_en = (r_state == ST_STEP) | ((r_state == ST_RUN) & ~w_bp_hit);

    // Executed-cycle counter, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_count <= '0;
        end else if (w_cpu_en) begin
            r_step_count <= r_step_count + 1'b1;
        end
    end

    assign bus.cpu_en     = w_cpu_en;
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.running    = (r_state == ST_RUN);
    assign bus.step_count = r_step_count;
    assign bus.dbg_state  = r_state;

endmodule
